// File: rtl/scope_pkg.sv
// Shared types and default constants for the triggered scope capture buffer.
package scope_pkg;

  typedef enum logic [2:0] {
    CAPTURE  = 3'd0,
    ARMED    = 3'd1,
    POSTFILL = 3'd2,
    READY    = 3'd3,
    PLAYBACK = 3'd4
  } state_t;

  typedef logic [6:0] word_t;

  localparam word_t MIDSCALE = 7'd64;

  localparam int DEPTH_LOG2_DEFAULT = 32'sd9;
  localparam int DECIM_DEFAULT      = 32'sd4;
  localparam int PRE_DEFAULT        = 32'sd240;
  localparam int POST_DEFAULT       = 32'sd240;
  localparam int LINES_DEFAULT      = 32'sd480;
  localparam int TIMEOUT_DEFAULT    = 32'sd1024;

  // Only the top seven bits of the offset-binary sample are kept.
  function automatic word_t stored_word(input logic [15:0] sample);
    return sample[15:9];
  endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Audio-in / scanline-out bundle between track generator, scope buffer and renderer.
interface scope_capture_if;
  import scope_pkg::*;

  logic [15:0] sample_in;
  logic        sample_valid;
  logic        frame_start;
  logic        line_req;
  word_t       line_sample;
  logic        line_valid;
  logic        locked;

  modport master (
    output sample_in, sample_valid, frame_start, line_req,
    input  line_sample, line_valid, locked
  );

  modport slave (
    input  sample_in, sample_valid, frame_start, line_req,
    output line_sample, line_valid, locked
  );

endinterface

// File: rtl/scope_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
module scope_ram #(
  parameter int DEPTH_LOG2 = 32'sd9,
  parameter int WIDTH      = 32'sd7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 32'sd1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];

  // Unreset storage so it maps onto block RAM; read data appears one cycle after rd_en.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered scope capture: decimate audio into a ring, trigger on a rising
// mid-scale crossing, then replay one stored sample per scanline for a frame.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int DECIM      = DECIM_DEFAULT,
  parameter int PRE        = PRE_DEFAULT,
  parameter int POST       = POST_DEFAULT,
  parameter int LINES      = LINES_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic            clk48,
  input logic            rst,
  scope_capture_if.slave bus
);

  localparam int DW = (DECIM > 32'sd1) ? $clog2(DECIM) : 32'sd1;
  localparam int FW = $clog2(PRE + 32'sd1);
  localparam int TW = $clog2(TIMEOUT + 32'sd1);
  localparam int PW = $clog2(POST + 32'sd1);
  localparam int LW = $clog2(LINES + 32'sd1);

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  localparam logic [DW-1:0] DEC_LAST    = DW'(DECIM - 32'sd1);
  localparam logic [FW-1:0] FILL_LAST   = FW'(PRE - 32'sd1);
  localparam logic [FW-1:0] FILL_FULL   = FW'(PRE);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 32'sd1);
  localparam logic [PW-1:0] POST_LAST   = PW'(POST - 32'sd1);
  localparam logic [LW-1:0] LINE_LAST   = LW'(LINES - 32'sd1);
  localparam addr_t         PRE_OFFSET  = addr_t'(PRE);
  localparam logic          SINGLE_POST = (POST == 32'sd1);

  state_t         state_r, state_next_s;
  logic [DW-1:0]  dec_cnt_r;
  addr_t          wptr_r, rptr_r, trig_addr_r;
  logic [FW-1:0]  fill_r;
  logic [TW-1:0]  tmo_r;
  logic [PW-1:0]  post_r;
  logic [LW-1:0]  line_cnt_r;
  logic           prev_bit6_r, triggered_r;
  logic           req_d_r, pb_d_r;

  word_t          word_s, rd_data_s;
  logic           dec_last_s, cross_s;
  logic           capturing_s, wr_en_s, rd_en_s, trig_s, enter_pb_s, leave_pb_s;

  assign word_s     = stored_word(bus.sample_in);
  assign dec_last_s = (dec_cnt_r == DEC_LAST);
  assign cross_s    = ~prev_bit6_r & word_s[6];

  scope_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32'sd7)
  ) u_ram (
    .clk     (clk48),
    .wr_en   (wr_en_s),
    .wr_addr (wptr_r),
    .wr_data (word_s),
    .rd_en   (rd_en_s),
    .rd_addr (rptr_r),
    .rd_data (rd_data_s)
  );

  // State register.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state_r <= CAPTURE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CAPTURE: begin
        if (wr_en_s && (fill_r == FILL_LAST)) state_next_s = ARMED;
        else                                  state_next_s = CAPTURE;
      end
      ARMED: begin
        if (trig_s) state_next_s = SINGLE_POST ? READY : POSTFILL;
        else        state_next_s = ARMED;
      end
      POSTFILL: begin
        if (wr_en_s && (post_r == POST_LAST)) state_next_s = READY;
        else                                  state_next_s = POSTFILL;
      end
      READY: begin
        if (enter_pb_s) state_next_s = PLAYBACK;
        else            state_next_s = READY;
      end
      PLAYBACK: begin
        if (leave_pb_s) state_next_s = CAPTURE;
        else            state_next_s = PLAYBACK;
      end
      default: state_next_s = CAPTURE;
    endcase
  end

  // State-decoded strobes; a READY-cycle line_req is never a playback read.
  always_comb begin
    capturing_s = 1'b0;
    rd_en_s     = 1'b0;
    enter_pb_s  = 1'b0;
    leave_pb_s  = 1'b0;
    case (state_r)
      CAPTURE, ARMED, POSTFILL: capturing_s = 1'b1;
      READY:    enter_pb_s = bus.frame_start;
      PLAYBACK: begin
        rd_en_s    = bus.line_req;
        leave_pb_s = bus.frame_start | (bus.line_req & (line_cnt_r == LINE_LAST));
      end
      default: capturing_s = 1'b0;
    endcase
    wr_en_s = capturing_s & bus.sample_valid & dec_last_s;
    trig_s  = (state_r == ARMED) & wr_en_s & (cross_s | (tmo_r == TMO_LAST));
  end

  // Decimation, write pointer, capture counters and playback pointer.
  always_ff @(posedge clk48) begin
    if (rst) begin
      dec_cnt_r   <= '0;
      wptr_r      <= '0;
      rptr_r      <= '0;
      trig_addr_r <= '0;
      fill_r      <= '0;
      tmo_r       <= '0;
      post_r      <= '0;
      line_cnt_r  <= '0;
      prev_bit6_r <= 1'b0;
      triggered_r <= 1'b0;
    end else begin
      if (capturing_s && bus.sample_valid) begin
        dec_cnt_r <= dec_last_s ? '0 : dec_cnt_r + DW'(32'd1);
      end
      if (wr_en_s) begin
        wptr_r      <= wptr_r + addr_t'(32'd1);
        prev_bit6_r <= word_s[6];
      end
      if (leave_pb_s) begin
        fill_r <= '0;
        tmo_r  <= '0;
        post_r <= '0;
      end else begin
        if (wr_en_s && (state_r == CAPTURE) && (fill_r != FILL_FULL)) begin
          fill_r <= fill_r + FW'(32'd1);
        end
        if (wr_en_s && (state_r == ARMED)) begin
          tmo_r <= tmo_r + TW'(32'd1);
        end
        if (trig_s) begin
          post_r <= PW'(32'd1);
        end else if (wr_en_s && (state_r == POSTFILL)) begin
          post_r <= post_r + PW'(32'd1);
        end
      end
      // A forced trigger lands on the current write but is reported unlocked.
      if (trig_s) begin
        trig_addr_r <= wptr_r;
        triggered_r <= cross_s;
      end
      if (enter_pb_s) begin
        rptr_r     <= trig_addr_r - PRE_OFFSET;
        line_cnt_r <= '0;
      end else if (rd_en_s) begin
        rptr_r     <= rptr_r + addr_t'(32'd1);
        line_cnt_r <= line_cnt_r + LW'(32'd1);
      end
    end
  end

  // Output register: RAM read lands at t+1, line output at t+2.
  always_ff @(posedge clk48) begin
    if (rst) begin
      req_d_r         <= 1'b0;
      pb_d_r          <= 1'b0;
      bus.line_valid  <= 1'b0;
      bus.line_sample <= MIDSCALE;
      bus.locked      <= 1'b0;
    end else begin
      req_d_r         <= bus.line_req;
      pb_d_r          <= rd_en_s;
      bus.line_valid  <= req_d_r;
      bus.line_sample <= pb_d_r ? rd_data_s : MIDSCALE;
      if (enter_pb_s) begin
        bus.locked <= triggered_r;
      end else if (leave_pb_s) begin
        bus.locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Randomized bench for scope_capture: expected lines come from searching the
// stored-sample sequence for the trigger, independent of pointers or states.
module tb_scope_capture;

  localparam int NWORDS = 512;
  localparam int PRE    = 240;
  localparam int POST   = 240;
  localparam int LINES  = 480;
  localparam int TMO    = 1024;

  logic clk48;
  logic rst;
  int   n_vec;
  int   n_err;
  int   stored1;
  int   trig_idx;
  bit   trig_ok;
  logic [15:0] smp[$];

  scope_capture_if b1();
  scope_capture_if b4();

  scope_capture #(.DEPTH_LOG2(9), .DECIM(1), .PRE(PRE), .POST(POST), .LINES(LINES), .TIMEOUT(TMO))
    dut1 (.clk48(clk48), .rst(rst), .bus(b1.slave));
  scope_capture #(.DEPTH_LOG2(9), .DECIM(4), .PRE(PRE), .POST(POST), .LINES(LINES), .TIMEOUT(TMO))
    dut4 (.clk48(clk48), .rst(rst), .bus(b4.slave));

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic drv(input int sel, input logic [15:0] s, input logic v, input logic fs, input logic lr);
    if (sel == 1) begin
      b1.sample_in = s; b1.sample_valid = v; b1.frame_start = fs; b1.line_req = lr;
    end else begin
      b4.sample_in = s; b4.sample_valid = v; b4.frame_start = fs; b4.line_req = lr;
    end
  endtask

  function automatic logic lv_of(input int sel);
    return (sel == 1) ? b1.line_valid : b4.line_valid;
  endfunction
  function automatic logic [6:0] ls_of(input int sel);
    return (sel == 1) ? b1.line_sample : b4.line_sample;
  endfunction
  function automatic logic lk_of(input int sel);
    return (sel == 1) ? b1.locked : b4.locked;
  endfunction

  task automatic strobe(input int sel, input logic [15:0] s);
    drv(sel, s, 1'b1, 1'b0, 1'b0);
    tick();
    drv(sel, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Feeds smp[from..to-1] as stored words; DECIM=4 gets three junk strobes before each.
  task automatic feed(input int sel, input int from, input int to, input int extras);
    for (int k = from; k < to; k++) begin
      if (sel == 4) repeat (3) strobe(sel, 16'($urandom()));
      strobe(sel, smp[k]);
    end
    if (sel == 1) stored1 += to - from;
    repeat (extras) strobe(sel, 16'($urandom()));
  endtask

  task automatic do_line(input int sel, input logic fs, output logic v1, output logic v2,
                         output logic [6:0] ls, output logic lk);
    drv(sel, 16'h0000, 1'b0, fs, 1'b1);
    tick();
    drv(sel, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk48); v1 = lv_of(sel);
    tick();
    @(negedge clk48); v2 = lv_of(sel); ls = ls_of(sel); lk = lk_of(sel);
    tick();
  endtask

  task automatic frame_pulse(input int sel, output logic lk);
    drv(sel, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    drv(sel, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk48); lk = lk_of(sel);
    tick();
  endtask

  // Trigger = first stored index >= PRE with a rising bit-6 edge, else the TMO-th armed sample.
  task automatic find_trig();
    trig_idx = PRE + TMO - 1;
    trig_ok  = 1'b0;
    for (int i = PRE; i < PRE + TMO; i++) begin
      if (!smp[i-1][15] && smp[i][15]) begin
        trig_idx = i;
        trig_ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic gen_cross_at(input int i);
    smp.delete();
    for (int k = 0; k < PRE + TMO + POST; k++) smp.push_back(16'($urandom()));
    for (int k = PRE - 1; k <= i - 2; k++) smp[k] = smp[k] | 16'h8000;
    smp[i-1] = smp[i-1] & 16'h7FFF;
    smp[i]   = smp[i] | 16'h8000;
  endtask

  task automatic test_reset();
    logic v1, v2, lk;
    logic [6:0] ls;
    rst = 1'b1;
    drv(1, 16'h0000, 1'b0, 1'b0, 1'b0);
    drv(4, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    @(negedge clk48);
    for (int s = 1; s <= 4; s += 3) begin
      n_vec++;
      if (ls_of(s) !== 7'd64 || lv_of(s) !== 1'b0 || lk_of(s) !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d: got sample=%0d valid=%b locked=%b, want 64 0 0", s, ls_of(s), lv_of(s), lk_of(s));
      end
    end
    tick();
    rst = 1'b0;
    stored1 = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      int s;
      s = (k < 4) ? 1 : 4;
      do_line(s, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || ls !== 7'd64 || lk !== 1'b0) begin
        n_err++;
        $display("FAIL idle_line dut%0d #%0d: got valid t+1/t+2=%b%b sample=%0d locked=%b, want 01 64 0", s, k, v1, v2, ls, lk);
      end
    end
  endtask

  task automatic test_square();
    logic v1, v2, lk;
    logic [6:0] ls, ex;
    smp.delete();
    for (int k = 0; k < PRE + TMO + POST; k++) smp.push_back(((k / 40) % 2) ? 16'hFFFF : 16'h0000);
    find_trig();
    feed(1, 0, trig_idx + POST, 4);
    frame_pulse(1, lk);
    n_vec++;
    if (lk !== trig_ok) begin
      n_err++; $display("FAIL square_locked: got %b want %b", lk, trig_ok);
    end
    for (int k = 0; k < LINES; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(1, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || ls !== ex || lk !== ((k == LINES - 1) ? 1'b0 : trig_ok)) begin
        n_err++;
        $display("FAIL square_line %0d: got valid=%b%b sample=%0d locked=%b, want 01 sample=%0d", k, v1, v2, ls, lk, ex);
      end
    end
    do_line(1, 1'b0, v1, v2, ls, lk);
    n_vec++;
    if (v2 !== 1'b1 || ls !== 7'd64 || lk !== 1'b0) begin
      n_err++; $display("FAIL square_after_lines: got valid=%b sample=%0d locked=%b, want 1 64 0", v2, ls, lk);
    end
  endtask

  task automatic test_forced();
    logic v1, v2, lk;
    logic [6:0] ls, ex;
    smp.delete();
    for (int k = 0; k < PRE + TMO + POST; k++) smp.push_back(16'h9000);
    find_trig();
    feed(1, 0, trig_idx + POST, 3);
    frame_pulse(1, lk);
    n_vec++;
    if (lk !== trig_ok) begin
      n_err++; $display("FAIL forced_locked: got %b want %b", lk, trig_ok);
    end
    for (int k = 0; k < LINES; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(1, (k == LINES - 1), v1, v2, ls, lk);
      n_vec++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || ls !== ex || lk !== 1'b0) begin
        n_err++;
        $display("FAIL forced_line %0d: got valid=%b%b sample=%0d locked=%b, want 01 sample=%0d locked=0", k, v1, v2, ls, lk, ex);
      end
    end
    do_line(1, 1'b0, v1, v2, ls, lk);
    n_vec++;
    if (v2 !== 1'b1 || ls !== 7'd64 || lk !== 1'b0) begin
      n_err++; $display("FAIL forced_after_last: got valid=%b sample=%0d locked=%b, want 1 64 0", v2, ls, lk);
    end
  endtask

  // Place the crossing so it is written at ring address 10, forcing the read start to wrap.
  task automatic test_wrap();
    logic v1, v2, lk;
    logic [6:0] ls, ex;
    int w0, i;
    w0 = stored1 % NWORDS;
    i  = PRE + (((10 - w0 - PRE) % NWORDS) + NWORDS) % NWORDS;
    gen_cross_at(i);
    find_trig();
    feed(1, 0, trig_idx + POST, 3);
    frame_pulse(1, lk);
    n_vec++;
    if (lk !== trig_ok) begin
      n_err++; $display("FAIL wrap_locked: got %b want %b", lk, trig_ok);
    end
    for (int k = 0; k < LINES; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(1, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v2 !== 1'b1 || ls !== ex) begin
        n_err++;
        $display("FAIL wrap_line %0d (addr %0d): got valid=%b sample=%0d, want 1 sample=%0d", k, (282 + k) % NWORDS, v2, ls, ex);
      end
    end
  endtask

  task automatic test_abort();
    logic v1, v2, lk;
    logic [6:0] ls, ex;
    gen_cross_at(PRE + 5);
    find_trig();
    feed(1, 0, trig_idx + POST, 2);
    frame_pulse(1, lk);
    for (int k = 0; k < 200; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(1, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v2 !== 1'b1 || ls !== ex || lk !== trig_ok) begin
        n_err++;
        $display("FAIL abort_line %0d: got valid=%b sample=%0d locked=%b, want 1 sample=%0d locked=%b", k, v2, ls, lk, ex, trig_ok);
      end
    end
    frame_pulse(1, lk);
    n_vec++;
    if (lk !== 1'b0) begin
      n_err++; $display("FAIL abort_unlock: got locked=%b want 0", lk);
    end
    do_line(1, 1'b0, v1, v2, ls, lk);
    n_vec++;
    if (v2 !== 1'b1 || ls !== 7'd64) begin
      n_err++; $display("FAIL abort_idle_line: got valid=%b sample=%0d, want 1 64", v2, ls);
    end
    // Fresh capture with a decoy crossing inside the pre-fill region.
    gen_cross_at(PRE + 30);
    smp[49] = smp[49] & 16'h7FFF;
    smp[50] = smp[50] | 16'h8000;
    find_trig();
    feed(1, 0, trig_idx + POST - 1, 0);
    do_line(1, 1'b1, v1, v2, ls, lk);
    n_vec++;
    if (v2 !== 1'b1 || ls !== 7'd64 || lk !== 1'b0) begin
      n_err++; $display("FAIL postfill_frame: got valid=%b sample=%0d locked=%b, want 1 64 0", v2, ls, lk);
    end
    feed(1, trig_idx + POST - 1, trig_idx + POST, 3);
    do_line(1, 1'b1, v1, v2, ls, lk);
    n_vec++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || ls !== 7'd64 || lk !== trig_ok) begin
      n_err++; $display("FAIL ready_frame_and_req: got valid=%b%b sample=%0d locked=%b, want 01 64 %b", v1, v2, ls, lk, trig_ok);
    end
    for (int k = 0; k < 100; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(1, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v2 !== 1'b1 || ls !== ex) begin
        n_err++; $display("FAIL refill_line %0d: got valid=%b sample=%0d, want 1 sample=%0d", k, v2, ls, ex);
      end
    end
  endtask

  task automatic test_midreset();
    logic v1, v2, lk;
    logic [6:0] ls;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stored1 = 0;
    @(negedge clk48);
    n_vec++;
    if (ls_of(1) !== 7'd64 || lv_of(1) !== 1'b0 || lk_of(1) !== 1'b0) begin
      n_err++; $display("FAIL midreset: got sample=%0d valid=%b locked=%b, want 64 0 0", ls_of(1), lv_of(1), lk_of(1));
    end
    tick();
    do_line(1, 1'b0, v1, v2, ls, lk);
    n_vec++;
    if (v2 !== 1'b1 || ls !== 7'd64 || lk !== 1'b0) begin
      n_err++; $display("FAIL midreset_line: got valid=%b sample=%0d locked=%b, want 1 64 0", v2, ls, lk);
    end
  endtask

  task automatic test_decim4();
    logic v1, v2, lk;
    logic [6:0] ls, ex;
    gen_cross_at(PRE);
    find_trig();
    feed(4, 0, trig_idx + POST, 5);
    frame_pulse(4, lk);
    n_vec++;
    if (lk !== trig_ok) begin
      n_err++; $display("FAIL decim4_locked: got %b want %b", lk, trig_ok);
    end
    for (int k = 0; k < LINES; k++) begin
      ex = smp[trig_idx - PRE + k][15:9];
      do_line(4, 1'b0, v1, v2, ls, lk);
      n_vec++;
      if (v2 !== 1'b1 || ls !== ex) begin
        n_err++; $display("FAIL decim4_line %0d: got valid=%b sample=%0d, want 1 sample=%0d", k, v2, ls, ex);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_square();
    test_forced();
    test_wrap();
    test_abort();
    test_midreset();
    test_decim4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
